load_store_unit: RTL and testbench

Parametrised multi-cycle load/store unit for the RV core, replacing the fixed one-cycle-delay load stall and separate load/store byte-lane logic with one handshaked block. It accepts one memory instruction at a time from the datapath and stalls the PC while the access is outstanding. It drives a valid/ack data-memory port with byte strobes and returns sign/zero-extended load data to the register file. It supports XLEN 32 or 64, variable memory wait states, an access-fault check and a bus timeout.

---
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle load/store unit. It accepts one memory instruction at a time
//   from the datapath and stalls the PC while the access is outstanding. It
//   drives a valid/ack data-memory port with byte strobes and returns
//   sign/zero-extended load data to the register file.
//
// Parameters
//   XLEN     data/address width (32 or 64)
//   TIMEOUT  maximum cycles in REQ without mem_ack; 0 disables the timeout
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/we/size/addr/wdata/rd request from the datapath
//   stall                           hold PC and instruction (combinational)
//   wb_valid/wb_rd/wb_data          load writeback (single-cycle pulse)
//   err_access                      misaligned/illegal-size request (comb)
//   err_timeout                     bus timeout pulse
//   mem_req/addr/be/wdata           registered memory request
//   mem_rdata/mem_ack               memory response
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              err_access,
  output logic              err_timeout,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, TERR} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic              we_reg;
  logic [2:0]        size_reg;
  logic [4:0]        rd_reg;
  logic [XLEN-1:0]   addr_reg, wdata_reg, wb_data_reg;
  logic [NB-1:0]     be_reg;

  logic              size_ok, align_ok, req_legal, accept;
  logic [NB-1:0]     size_mask, be_fmt;
  logic [XLEN-1:0]   wdata_fmt, rdata_sh, load_ext;

  // Request legality: size encoding and natural alignment.
  always_comb begin
    size_ok = (req_size != 3'b111);
    if (XLEN == 32 && (req_size == 3'b011 || req_size == 3'b110))
      size_ok = 1'b0;
    case (req_size[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = (req_addr[2:0] == 3'b000);
    endcase
    req_legal = size_ok && align_ok;
  end

  assign accept = (state_reg == IDLE) && req_valid && req_legal;

  // Byte strobes: size mask placed at the lane offset; loads strobe nothing.
  always_comb begin
    case (req_size[1:0])
      2'b00:   size_mask = NB'(8'h01);
      2'b01:   size_mask = NB'(8'h03);
      2'b10:   size_mask = NB'(8'h0F);
      default: size_mask = NB'(8'hFF);
    endcase
    be_fmt = req_we ? (size_mask << req_addr[OFFW-1:0]) : '0;
  end

  // Store data replicated so every lane that could be strobed sees it.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign wdata_fmt[8*gi +: 8] =
        (req_size[1:0] == 2'b00) ? req_wdata[7:0] :
        (req_size[1:0] == 2'b01) ? req_wdata[8*(gi % 2) +: 8] :
        (req_size[1:0] == 2'b10) ? req_wdata[8*(gi % 4) +: 8] :
                                   req_wdata[8*gi +: 8];
  end

  // Load data: bring the addressed lane down to bit 0, then extend.
  assign rdata_sh = mem_rdata >> {addr_reg[OFFW-1:0], 3'b000};

  always_comb begin
    case (size_reg)
      3'b000:  load_ext = XLEN'($signed(rdata_sh[7:0]));
      3'b001:  load_ext = XLEN'($signed(rdata_sh[15:0]));
      3'b010:  load_ext = XLEN'($signed(rdata_sh[31:0]));
      3'b100:  load_ext = XLEN'(rdata_sh[7:0]);
      3'b101:  load_ext = XLEN'(rdata_sh[15:0]);
      3'b110:  load_ext = XLEN'(rdata_sh[31:0]);
      default: load_ext = rdata_sh;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = REQ;
      REQ: begin
        if (mem_ack)
          state_next = we_reg ? IDLE : RESP;
        else if (TIMEOUT != 0 && cnt_reg == CNT_LAST)
          state_next = TERR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latched request, timeout counter and captured load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      size_reg    <= 3'b000;
      rd_reg      <= 5'd0;
      addr_reg    <= '0;
      be_reg      <= '0;
      wdata_reg   <= '0;
      wb_data_reg <= '0;
    end else if (accept) begin
      cnt_reg   <= '0;
      we_reg    <= req_we;
      size_reg  <= req_size;
      rd_reg    <= req_rd;
      addr_reg  <= req_addr;
      be_reg    <= be_fmt;
      wdata_reg <= wdata_fmt;
    end else if (state_reg == REQ) begin
      if (mem_ack) begin
        if (!we_reg) wb_data_reg <= load_ext;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // Outputs. stall and err_access are forced low while reset is held so
  // the core sees every output at 0 even if it keeps req_valid asserted.
  always_comb begin
    mem_req     = (state_reg == REQ);
    wb_valid    = (state_reg == RESP);
    err_timeout = (state_reg == TERR);
    err_access  = rst_n && (state_reg == IDLE) && req_valid && !req_legal;
    stall       = 1'b0;
    if (rst_n) begin
      case (state_reg)
        IDLE:    stall = req_valid && req_legal;
        REQ:     stall = !(mem_ack && we_reg);
        default: stall = 1'b0;
      endcase
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_be    = be_reg;
  assign mem_wdata = wdata_reg;
  assign wb_rd     = rd_reg;
  assign wb_data   = wb_data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TO64 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // 64-bit DUT (scoreboarded random traffic)
  logic        req_valid = 0, req_we = 0, mem_ack = 0;
  logic [2:0]  req_size = 0;
  logic [63:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic [4:0]  req_rd = 0;
  logic        stall, wb_valid, err_access, err_timeout, mem_req;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data, mem_addr, mem_wdata;
  logic [7:0]  mem_be;

  load_store_unit #(.XLEN(64), .TIMEOUT(TO64)) u64 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .err_access(err_access), .err_timeout(err_timeout),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack));

  // 32-bit DUT (directed checks)
  logic        rv32 = 0, we32 = 0, ack32 = 0;
  logic [2:0]  sz32 = 0;
  logic [31:0] ad32 = 0, wd32 = 0, rdat32 = 0;
  logic [4:0]  rd32 = 0;
  logic        st32, wbv32, ea32, et32, mreq32;
  logic [4:0]  wbrd32;
  logic [31:0] wbd32, maddr32, mwd32;
  logic [3:0]  mbe32;

  load_store_unit #(.XLEN(32), .TIMEOUT(16)) u32 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv32), .req_we(we32),
    .req_size(sz32), .req_addr(ad32), .req_wdata(wd32),
    .req_rd(rd32), .stall(st32), .wb_valid(wbv32), .wb_rd(wbrd32),
    .wb_data(wbd32), .err_access(ea32), .err_timeout(et32),
    .mem_req(mreq32), .mem_addr(maddr32), .mem_be(mbe32),
    .mem_wdata(mwd32), .mem_rdata(rdat32), .mem_ack(ack32));

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // ---------------- reference model ----------------
  function automatic int nbytes(logic [2:0] size);
    return 1 << size[1:0];
  endfunction

  function automatic bit model_legal(logic [2:0] size, logic [63:0] addr, int xlen);
    if (size == 3'd7) return 0;
    if (xlen == 32 && (size == 3'd3 || size == 3'd6)) return 0;
    return (addr % nbytes(size)) == 0;
  endfunction

  function automatic logic [7:0] model_be(logic [2:0] size, logic [63:0] addr);
    int off = int'(addr % 8);
    logic [7:0] be = '0;
    for (int i = 0; i < 8; i++) be[i] = (i >= off) && (i < off + nbytes(size));
    return be;
  endfunction

  function automatic logic [63:0] model_wdata(logic [2:0] size, logic [63:0] wd);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = wd[8*(i % nbytes(size)) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_load(logic [2:0] size, logic [63:0] addr,
                                             logic [63:0] rd);
    int n = nbytes(size);
    logic [63:0] v = rd >> (8 * (addr % 8));
    logic [63:0] m;
    if (n < 8) begin
      m = (64'h1 << (8 * n)) - 1;
      v = v & m;
      if (!size[2] && v[8*n-1]) v = v | ~m;
    end
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  localparam int K_ACC = 0, K_MREQ = 1, K_WB = 2, K_TO = 3;
  typedef struct {
    int          kind;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic        we;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  function automatic exp_t mk(int kind, logic [63:0] a, logic [63:0] b,
                              logic [63:0] c, logic we, int cyc);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c; e.we = we; e.cyc = cyc;
    return e;
  endfunction

  function automatic bit pop_expect(int kind, output exp_t e);
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL event_order: got event kind %0d expected none pending", kind);
      return 0;
    end
    e = exp_q.pop_front();
    if (e.kind != kind) begin
      $display("FAIL event_order: got event kind %0d expected kind %0d", kind, e.kind);
      return 0;
    end
    passes++;
    return 1;
  endfunction

  // Monitor: samples on the falling edge, pops expectations as events appear.
  logic prev_mreq = 0;
  int   req_cyc = 0, exp_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_mreq = 0;
      req_cyc = 0;
    end else begin
      if (err_access) void'(pop_expect(K_ACC, e));
      if (mem_req && !prev_mreq) begin
        req_cyc = 0;
        exp_cyc = 0;
        if (pop_expect(K_MREQ, e)) begin
          exp_cyc = e.cyc;
          chk("mem_addr", mem_addr, e.a);
          chk("mem_be", 64'(mem_be), e.b);
          if (e.we) chk("mem_wdata", mem_wdata, e.c);
        end
      end
      if (mem_req) req_cyc++;
      if (!mem_req && prev_mreq) chk("mem_req_cycles", 64'(req_cyc), 64'(exp_cyc));
      if (wb_valid && pop_expect(K_WB, e)) begin
        chk("wb_rd", 64'(wb_rd), e.a);
        chk("wb_data", wb_data, e.b);
      end
      if (err_timeout) void'(pop_expect(K_TO, e));
      prev_mreq = mem_req;
    end
  end

  // ---------------- driver for the 64-bit DUT ----------------
  task automatic run_txn(input logic we, input logic [2:0] size,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [4:0] rd, input int waits,
                         input logic [63:0] rdata);
    bit tmo;
    int stalls, exp_st;
    @(posedge clk); #1;
    mem_ack = 0;
    req_valid = 1; req_we = we; req_size = size; req_addr = addr;
    req_wdata = wd; req_rd = rd; mem_rdata = rdata;
    if (!model_legal(size, addr, 64)) begin
      exp_q.push_back(mk(K_ACC, 0, 0, 0, 0, 0));
      @(negedge clk);
      chk("acc_stall", 64'(stall), 0);
      chk("acc_mem_req", 64'(mem_req), 0);
      return;
    end
    tmo = (waits >= TO64);
    exp_q.push_back(mk(K_MREQ, addr, we ? 64'(model_be(size, addr)) : 64'h0,
                       model_wdata(size, wd), we, tmo ? TO64 : waits + 1));
    if (tmo) exp_q.push_back(mk(K_TO, 0, 0, 0, 0, 0));
    else if (!we) exp_q.push_back(mk(K_WB, 64'(rd), model_load(size, addr, rdata), 0, 0, 0));
    exp_st = tmo ? 1 + TO64 : (we ? 1 + waits : 2 + waits);
    stalls = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      @(posedge clk); #1;
      mem_ack = (!tmo && c == waits + 1);
    end
    chk("stall_cycles", 64'(stalls), 64'(exp_st));
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    req_valid = 0; mem_ack = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    chk("rst_stall", 64'(stall), 0);
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_wb_valid", 64'(wb_valid), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wb_rd", 64'(wb_rd), 0);
    chk("rst_mem_be", 64'(mem_be), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // XLEN=32: LB 0x1003, no waits
    @(posedge clk); #1;
    rv32 = 1; we32 = 0; sz32 = 3'b000; ad32 = 32'h1003; rd32 = 5'd7; rdat32 = 32'h80FF_0000;
    @(negedge clk); chk("lb32_stall_c1", 64'(st32), 1);
    @(posedge clk); #1 ack32 = 1;
    @(negedge clk);
    chk("lb32_mem_req", 64'(mreq32), 1);
    chk("lb32_mem_be", 64'(mbe32), 0);
    chk("lb32_stall_c2", 64'(st32), 1);
    @(posedge clk); #1 ack32 = 0;
    @(negedge clk);
    chk("lb32_wb_valid", 64'(wbv32), 1);
    chk("lb32_wb_data", 64'(wbd32), 64'hFFFF_FF80);
    chk("lb32_wb_rd", 64'(wbrd32), 7);
    chk("lb32_stall_c3", 64'(st32), 0);
    chk("lb32_mem_req_off", 64'(mreq32), 0);

    // XLEN=32: SH 0x2002, 3 wait states, accepted back-to-back
    @(posedge clk); #1;
    we32 = 1; sz32 = 3'b001; ad32 = 32'h2002; wd32 = 32'h1234_ABCD;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sh32_mem_be", 64'(mbe32), 64'hC);
    chk("sh32_mem_wdata", 64'(mwd32), 64'hABCD_ABCD);
    repeat (3) @(posedge clk);
    #1 ack32 = 1;
    @(negedge clk);
    chk("sh32_ack_stall", 64'(st32), 0);
    chk("sh32_ack_mem_req", 64'(mreq32), 1);
    @(posedge clk); #1 ack32 = 0; rv32 = 0;
    @(negedge clk);
    chk("sh32_done_mem_req", 64'(mreq32), 0);
    chk("sh32_no_wb", 64'(wbv32), 0);

    // XLEN=32 access faults
    @(posedge clk); #1;
    rv32 = 1; we32 = 0; sz32 = 3'b011; ad32 = 32'h1000;
    #1 chk("rv32_size011_err", 64'(ea32), 1);
    chk("rv32_size011_stall", 64'(st32), 0);
    sz32 = 3'b010; ad32 = 32'h1002;
    #1 chk("lw32_misalign_err", 64'(ea32), 1);
    @(negedge clk); chk("lw32_misalign_mem_req", 64'(mreq32), 0);
    @(posedge clk); #1 rv32 = 0;

    // XLEN=64 directed: LWU / LW at offset 4, misaligned LW, timeout
    run_txn(0, 3'b110, 64'h0000_0000_0000_1004, 0, 5'd3, 0, 64'hF000_0001_0000_0000);
    run_txn(0, 3'b010, 64'h0000_0000_0000_1004, 0, 5'd4, 1, 64'hF000_0001_0000_0000);
    run_txn(0, 3'b010, 64'h0000_0000_0000_1002, 0, 5'd5, 0, 0);
    run_txn(0, 3'b010, 64'h0000_0000_0000_2000, 0, 5'd6, 99, 64'h1);
    run_txn(1, 3'b011, 64'h0000_0000_0000_3000, 64'h0123_4567_89AB_CDEF, 0, TO64 - 1, 0);
    idle_cycle();

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      logic [2:0]  sz = 3'($urandom_range(0, 7));
      logic [63:0] a  = {$urandom, $urandom};
      if ($urandom_range(0, 4) != 0) a = a & ~64'(nbytes(sz) - 1);
      run_txn(1'($urandom_range(0, 1)), sz, a, {$urandom, $urandom},
              5'($urandom_range(0, 31)), $urandom_range(0, 5), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    // Reset during the REQ wait of a load
    @(posedge clk); #1;
    req_valid = 1; req_we = 0; req_size = 3'b011; req_addr = 64'h4000; req_rd = 5'd9;
    exp_q.push_back(mk(K_MREQ, 64'h4000, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_mem_req", 64'(mem_req), 0);
    chk("arst_stall", 64'(stall), 0);
    chk("arst_wb_valid", 64'(wb_valid), 0);
    chk("arst_err_timeout", 64'(err_timeout), 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_wb_rd", 64'(wb_rd), 0);
    req_valid = 0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    run_txn(1, 3'b000, 64'h0000_0000_0000_5005, 64'h0000_0000_0000_00A5, 0, 0, 0);
    idle_cycle();
    repeat (8) @(posedge clk);

    chk("pending_events", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
